// File: rtl/matrix_operand_bank_pkg.sv
// Shared types and sizing helpers for the matrix operand bank and its stores.
package matrix_pkg;

  localparam int DEFAULT_N  = 3;
  localparam int DEFAULT_DW = 4;

  typedef enum logic [1:0] {IDLE, ARMED, STREAM, DONE} state_e;

  typedef enum logic {RD_COL, RD_ROW} rd_mode_e;

  // Index width for a range of `count` items; never narrower than one bit.
  function automatic int width_of(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/matrix_operand_bank_store.sv
// One N x N operand memory, filled serially in row-major order, read back as a
// column or a row selected by step index k.
module operand_store
  import matrix_pkg::*;
#(
  parameter int N  = DEFAULT_N,
  parameter int DW = DEFAULT_DW,
  parameter int AW = width_of(N * N),
  parameter int KW = width_of(N)
) (
  input  logic            clk,
  input  logic            clear,
  input  logic            wr_en,
  input  logic [DW-1:0]   wr_data,
  input  logic            cnt_clr,
  input  logic            cnt_hold,
  input  rd_mode_e        rd_mode,
  input  logic [KW-1:0]   rd_k,
  output logic            full,
  output logic [N*DW-1:0] rd_data
);

  localparam int DEPTH = N * N;
  // The counter must be able to hold DEPTH itself, which is the "full" value.
  localparam int CW = width_of(DEPTH + 1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;

  assign full = (cnt_q == CW'(DEPTH));

  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (wr_en && !full) begin
      mem_d[cnt_q[AW-1:0]] = wr_data;
      cnt_d = cnt_q + CW'(1);
    end
    if (cnt_clr && !cnt_hold) begin
      cnt_d = '0;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < N; i++) begin
      if (rd_mode == RD_COL) begin
        rd_data[i*DW +: DW] = mem_q[AW'(i * N + int'(rd_k))];
      end else begin
        rd_data[i*DW +: DW] = mem_q[AW'(int'(rd_k) * N + i)];
      end
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      for (int a = 0; a < DEPTH; a++) begin
        mem_q[a] <= '0;
      end
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/matrix_operand_bank.sv
// Holds weight matrix W and input matrix X and streams them to the PE array in
// outer-product order: step k presents W column k alongside X row k.
module matrix_operand_bank
  import matrix_pkg::*;
#(
  parameter int N  = DEFAULT_N,
  parameter int DW = DEFAULT_DW,
  parameter int AW = width_of(N * N),
  parameter int KW = width_of(N)
) (
  input  logic            clk,
  input  logic            clear,
  input  logic [DW-1:0]   data_in,
  input  logic            load_w,
  input  logic            load_x,
  input  logic            keep_w,
  input  logic            go,
  input  logic            out_ready,
  output logic            w_full,
  output logic            x_full,
  output logic            start,
  output logic            out_valid,
  output logic [KW-1:0]   out_step,
  output logic [N*DW-1:0] w_col,
  output logic [N*DW-1:0] x_row,
  output logic            done
);

  state_e          state_q, state_d;
  logic [KW-1:0]   step_q, step_d;
  logic            w_we, x_we, in_done;
  logic [N*DW-1:0] w_rd, x_rd;

  // W wins a simultaneous load; X only goes through when W did not take the cycle.
  assign w_we    = (state_q == IDLE) && load_w && !w_full;
  assign x_we    = (state_q == IDLE) && load_x && !x_full && !w_we;
  assign in_done = (state_q == DONE);

  operand_store #(.N(N), .DW(DW), .AW(AW), .KW(KW)) u_w_store (
    .clk      (clk),
    .clear    (clear),
    .wr_en    (w_we),
    .wr_data  (data_in),
    .cnt_clr  (in_done),
    .cnt_hold (keep_w),
    .rd_mode  (RD_COL),
    .rd_k     (step_q),
    .full     (w_full),
    .rd_data  (w_rd)
  );

  operand_store #(.N(N), .DW(DW), .AW(AW), .KW(KW)) u_x_store (
    .clk      (clk),
    .clear    (clear),
    .wr_en    (x_we),
    .wr_data  (data_in),
    .cnt_clr  (in_done),
    .cnt_hold (1'b0),
    .rd_mode  (RD_ROW),
    .rd_k     (step_q),
    .full     (x_full),
    .rd_data  (x_rd)
  );

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      IDLE: begin
        if (w_full && x_full) state_d = ARMED;
      end
      ARMED: begin
        if (go) begin
          state_d = STREAM;
          step_d  = '0;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (step_q == KW'(N - 1)) begin
            state_d = DONE;
            step_d  = '0;
          end else begin
            step_d = step_q + KW'(1);
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start     = (state_q == ARMED);
    out_valid = (state_q == STREAM);
    done      = (state_q == DONE);
    out_step  = step_q;
    w_col     = (state_q == STREAM) ? w_rd : '0;
    x_row     = (state_q == STREAM) ? x_rd : '0;
  end

endmodule

// File: tb/tb_matrix_operand_bank.sv
// Self-checking bench: a matrix-level model plus scoreboard for the 3x3/4-bit
// bank, and directed literal checks for a 4x4/8-bit instance.
module tb_matrix_operand_bank;
  import matrix_pkg::*;

  localparam int N   = 3;
  localparam int DW  = 4;
  localparam int N4  = 4;
  localparam int DW4 = 8;

  logic clk = 1'b0;
  logic clear;
  always #5 clk = ~clk;

  logic [DW-1:0]   data_in;
  logic            load_w, load_x, keep_w, go, out_ready;
  logic            w_full, x_full, start, out_valid, done;
  logic [1:0]      out_step;
  logic [N*DW-1:0] w_col, x_row;

  logic [DW4-1:0]    d4_data_in;
  logic              d4_load_w, d4_load_x, d4_keep_w, d4_go, d4_out_ready;
  logic              d4_w_full, d4_x_full, d4_start, d4_out_valid, d4_done;
  logic [1:0]        d4_out_step;
  logic [N4*DW4-1:0] d4_w_col, d4_x_row;

  matrix_operand_bank #(.N(N), .DW(DW)) dut (
    .clk(clk), .clear(clear), .data_in(data_in), .load_w(load_w), .load_x(load_x),
    .keep_w(keep_w), .go(go), .out_ready(out_ready), .w_full(w_full), .x_full(x_full),
    .start(start), .out_valid(out_valid), .out_step(out_step), .w_col(w_col),
    .x_row(x_row), .done(done)
  );

  matrix_operand_bank #(.N(N4), .DW(DW4)) dut4 (
    .clk(clk), .clear(clear), .data_in(d4_data_in), .load_w(d4_load_w), .load_x(d4_load_x),
    .keep_w(d4_keep_w), .go(d4_go), .out_ready(d4_out_ready), .w_full(d4_w_full),
    .x_full(d4_x_full), .start(d4_start), .out_valid(d4_out_valid), .out_step(d4_out_step),
    .w_col(d4_w_col), .x_row(d4_x_row), .done(d4_done)
  );

  int checks   = 0;
  int failures = 0;

  // Matrix-level model of the 3x3 bank: W and X contents plus fill counts.
  int wm [N*N];
  int xm [N*N];
  int wcnt, xcnt;

  typedef struct {
    int              k;
    logic [N*DW-1:0] wc;
    logic [N*DW-1:0] xr;
  } step_t;

  step_t sb[$];
  bit    done_pending = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < N*N; i++) begin
      wm[i] = 0;
      xm[i] = 0;
    end
    wcnt = 0;
    xcnt = 0;
    sb.delete();
    done_pending = 1'b0;
  endtask

  task automatic modelLoad(input bit lw, input bit lx, input int v);
    if (lw && wcnt < N*N) begin
      wm[wcnt] = v;
      wcnt++;
    end else if (lx && xcnt < N*N) begin
      xm[xcnt] = v;
      xcnt++;
    end
  endtask

  // Step k: slice i of w_col is W[i][k], slice j of x_row is X[k][j].
  task automatic modelGo();
    step_t s;
    for (int k = 0; k < N; k++) begin
      s.k  = k;
      s.wc = '0;
      s.xr = '0;
      for (int i = 0; i < N; i++) begin
        s.wc[i*DW +: DW] = DW'(wm[i*N + k]);
        s.xr[i*DW +: DW] = DW'(xm[k*N + i]);
      end
      sb.push_back(s);
    end
  endtask

  task automatic modelDone(input bit keep);
    xcnt = 0;
    if (!keep) wcnt = 0;
  endtask

  task automatic applyStimulus(input bit lw, input bit lx, input logic [DW-1:0] v);
    load_w  = lw;
    load_x  = lx;
    data_in = v;
    modelLoad(lw, lx, int'(v));
    @(posedge clk);
    #1;
    load_w = 1'b0;
    load_x = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_seen", done, 1);
  endtask

  // Scoreboard compare for the 3x3 bank, every cycle outside reset.
  always @(negedge clk) begin
    if (!clear) begin
      checkOutput("done_pulse", done, done_pending);
      done_pending = 1'b0;
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_step: out_step=%0d with no step outstanding", out_step);
        end else begin
          checkOutput("out_step", out_step, sb[0].k);
          checkOutput("w_col", w_col, sb[0].wc);
          checkOutput("x_row", x_row, sb[0].xr);
          if (out_ready) begin
            if (sb.size() == 1) done_pending = 1'b1;
            void'(sb.pop_front());
          end
        end
      end else begin
        checkOutput("w_col_gated", w_col, 0);
        checkOutput("x_row_gated", x_row, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [N4*DW4-1:0] exp_w4, exp_x4;
  logic [DW-1:0]     run2_x [N*N];

  initial begin
    clear = 1'b1;
    data_in = '0; load_w = 0; load_x = 0; keep_w = 0; go = 0; out_ready = 0;
    d4_data_in = '0; d4_load_w = 0; d4_load_x = 0; d4_keep_w = 0; d4_go = 0; d4_out_ready = 0;
    run2_x = '{4'd3, 4'd1, 4'd4, 4'd1, 4'd5, 4'd9, 4'd2, 4'd6, 4'd5};
    resetModel();
    repeat (2) @(negedge clk);
    checkOutput("rst_w_full", w_full, 0);
    checkOutput("rst_x_full", x_full, 0);
    checkOutput("rst_start", start, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_step", out_step, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_w_col", w_col, 0);
    checkOutput("rst_x_row", x_row, 0);
    @(posedge clk);
    #1 clear = 1'b0;

    // Run 1: W=1..11 (overflow, first with load_x too), X=10..15,0,1,2, keep W.
    for (int v = 1; v <= 11; v++) begin
      applyStimulus(1'b1, (v == 1), DW'(v));
      @(negedge clk);
      if (v == 8) checkOutput("w_full_after8", w_full, 0);
      if (v == 9) checkOutput("w_full_after9", w_full, 1);
    end
    checkOutput("x_empty_after_w", x_full, 0);
    for (int i = 0; i < N*N; i++) applyStimulus(1'b0, 1'b1, DW'(10 + i));
    @(negedge clk);
    checkOutput("x_full_after9", x_full, 1);
    checkOutput("start_not_yet", start, 0);
    @(negedge clk);
    checkOutput("start_armed", start, 1);
    checkOutput("armed_not_valid", out_valid, 0);
    // go together with loads in ARMED: go wins, loads are dropped
    go = 1'b1; out_ready = 1'b1; keep_w = 1'b1; load_w = 1'b1; load_x = 1'b1; data_in = 4'd5;
    modelGo();
    @(posedge clk);
    #1 go = 1'b0; load_w = 1'b0; load_x = 1'b0;
    @(negedge clk);
    checkOutput("lit_step0_w", w_col, 12'h741);
    checkOutput("lit_step0_x", x_row, 12'hCBA);
    checkOutput("start_off_stream", start, 0);
    waitDone(10);
    modelDone(1'b1);
    @(negedge clk);
    checkOutput("keep_w_full", w_full, 1);
    checkOutput("x_cleared", x_full, 0);
    checkOutput("done_single", done, 0);

    // Run 2: reuse W, new X only, back-pressure at step 1, then drop W.
    keep_w = 1'b0;
    for (int i = 0; i < N*N; i++) applyStimulus(1'b0, 1'b1, run2_x[i]);
    @(negedge clk);
    @(negedge clk);
    checkOutput("rearm_no_w_load", start, 1);
    go = 1'b1; out_ready = 1'b1;
    modelGo();
    @(posedge clk);
    #1 go = 1'b0;
    checkOutput("lit_reuse_w", w_col, 12'h741);
    @(posedge clk);
    #1 out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("bp_step", out_step, 1);
      checkOutput("bp_w_col", w_col, 12'h852);
      checkOutput("bp_x_row", x_row, 12'h951);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    waitDone(10);
    modelDone(1'b0);
    checkOutput("all_steps_delivered", sb.size(), 0);
    @(negedge clk);
    checkOutput("w_dropped", w_full, 0);
    checkOutput("x_dropped", x_full, 0);

    // Run 3: reload, then clear in the middle of the stream.
    for (int v = 1; v <= 9; v++) applyStimulus(1'b1, 1'b0, DW'(v));
    for (int v = 2; v <= 10; v++) applyStimulus(1'b0, 1'b1, DW'(v));
    @(negedge clk);
    @(negedge clk);
    checkOutput("run3_armed", start, 1);
    go = 1'b1; out_ready = 1'b1;
    modelGo();
    @(posedge clk);
    #1 go = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("run3_at_step1", out_step, 1);
    clear = 1'b1;
    resetModel();
    #1;
    checkOutput("clr_out_valid", out_valid, 0);
    checkOutput("clr_out_step", out_step, 0);
    checkOutput("clr_start", start, 0);
    checkOutput("clr_w_full", w_full, 0);
    checkOutput("clr_x_full", x_full, 0);
    checkOutput("clr_done", done, 0);
    checkOutput("clr_w_col", w_col, 0);
    checkOutput("clr_x_row", x_row, 0);
    @(posedge clk);
    #1 clear = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("post_clr_idle", start, 0);

    // N=4, DW=8: W=0..15, X=identity.
    for (int v = 0; v < N4*N4; v++) begin
      d4_data_in = DW4'(v); d4_load_w = 1'b1;
      @(posedge clk);
      #1 d4_load_w = 1'b0;
    end
    for (int v = 0; v < N4*N4; v++) begin
      d4_data_in = (v % (N4 + 1) == 0) ? 8'd1 : 8'd0; d4_load_x = 1'b1;
      @(posedge clk);
      #1 d4_load_x = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    checkOutput("n4_armed", d4_start, 1);
    d4_go = 1'b1; d4_out_ready = 1'b1;
    @(posedge clk);
    #1 d4_go = 1'b0;
    for (int k = 0; k < N4; k++) begin
      @(negedge clk);
      for (int i = 0; i < N4; i++) begin
        exp_w4[i*DW4 +: DW4] = DW4'(4*i + k);
        exp_x4[i*DW4 +: DW4] = (i == k) ? 8'd1 : 8'd0;
      end
      checkOutput("n4_valid", d4_out_valid, 1);
      checkOutput("n4_step", d4_out_step, k);
      checkOutput("n4_w_col", d4_w_col, exp_w4);
      checkOutput("n4_x_row", d4_x_row, exp_x4);
    end
    @(negedge clk);
    checkOutput("n4_done", d4_done, 1);
    checkOutput("n4_valid_drop", d4_out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matrix_operand_bank.md
Name: matrix_operand_bank

Overview:
- Parametrised successor of the fixed 3x3, 4-bit operand memory for the matrix multiplication datapath.
- Holds one N x N weight matrix W and one N x N input matrix X, each loaded serially in row-major order.
- After both are full and the controller issues go, streams N steps to the PE array. Step k presents W column k and X row k, which is the outer-product order.
- Adds a valid/ready handshake, a done pulse and optional W retention, so consecutive X batches can reuse the same weights.

Parameters:
- N, 3, matrix dimension; must be >= 2.
- DW, 4, element width in bits.
- AW, $clog2(N*N), element address width (derived; do not override).
- KW, $clog2(N), step index width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- clear  in  1  asynchronous, active-high reset.
- data_in  in  DW  element to store.
- load_w  in  1  store data_in into the next W slot.
- load_x  in  1  store data_in into the next X slot.
- keep_w  in  1  retain W after the stream completes.
- go  in  1  start streaming; honoured only in ARMED.
- out_ready  in  1  consumer accepts the current step.
- w_full  out  1  all N*N W slots written.
- x_full  out  1  all N*N X slots written.
- start  out  1  registered; high exactly in ARMED.
- out_valid  out  1  current step is valid.
- out_step  out  KW  index k of the current step.
- w_col  out  N*DW  slice i = W[i][k] = w_mem[i*N+k].
- x_row  out  N*DW  slice j = X[k][j] = x_mem[k*N+j].
- done  out  1  one-cycle pulse after the last step is accepted.

Behaviour:
- Reset (clear=1, asynchronous):
  - Memories, both write counters, out_step and done are 0.
  - State is IDLE, and all outputs are 0.
- Loading (IDLE only):
  - Each clk with load_w=1 and w_full=0 writes w_mem[w_cnt] and increments w_cnt.
  - When w_cnt reaches N*N, w_full=1 and the counter holds; it never wraps.
  - X loads the same way through load_x, x_cnt and x_full.
  - If load_w and load_x are both 1, W has priority. If W is full, the X write proceeds that cycle.
  - Loads to a full matrix are ignored, with no overwrite and no error.
  - Loads in ARMED, STREAM or DONE are ignored.
- State IDLE -> ARMED:
  - Transition is on the edge after both w_full and x_full are 1.
  - start=1 from the following cycle.
- State ARMED -> STREAM:
  - Transition is on the clk where go=1.
  - out_valid=1 and out_step=0 in the next cycle, giving 1-cycle latency from go.
  - go outside ARMED is ignored.
- State STREAM:
  - w_col and x_row are combinational from the memories and out_step.
  - On out_valid & out_ready, out_step increments.
  - Without out_ready, out_step and the data hold stable; this is a no-drop rule.
  - The handshake at out_step=N-1 moves to DONE, and out_valid drops the next cycle.
- State DONE (one cycle):
  - done=1.
  - x_cnt clears, and x_full=0.
  - If keep_w is sampled 1 in this cycle, w_cnt and w_full are retained. Otherwise w_cnt clears and w_full=0.
  - Next state is IDLE.
  - Memory contents are not erased; they are overwritten by the next loads.
- Output gating: w_col and x_row are driven to 0 whenever out_valid=0.
- Simultaneous events:
  - load_* together with go in ARMED: go wins and the loads are ignored.
  - clear during any state returns to reset values immediately, aborting the stream, with no done pulse.

Decomposition:
- Shared package matrix_pkg:
  - state enum {IDLE, ARMED, STREAM, DONE};
  - default N and DW constants;
  - a width helper for AW and KW.
- Sub-module operand_store(N, DW), instantiated twice (W and X):
  - contains the memory, write counter and full flag;
  - has a sync clear-counter input with a hold option;
  - has a read port with mode select, COL returning elements i*N+k and ROW returning elements k*N+j.
- The top level holds the FSM, the step counter and output gating.

Test Plan:
- Default N=3, DW=4:
  - Stimulus: load W=1..9, X=10..15,0,1,2, then go with out_ready=1.
  - Response: step0 w_col={1,4,7}, x_row={10,11,12}; step1 {2,5,8}/{13,14,15}; step2 {3,6,9}/{0,1,2}.
  - Then done is a single pulse 1 cycle after step2, and start=1 only while ARMED.
- Overflow:
  - Stimulus: apply 11 load_w pulses with values 1..11.
  - Response: w_full=1 after the 9th, and w_mem[8]=9, i.e. the last two loads are ignored.
- Back-pressure:
  - Stimulus: hold out_ready=0 for 3 cycles at step1.
  - Response: out_step=1 and data are stable throughout, and all 3 steps are still delivered.
- Weight reuse:
  - Stimulus: keep_w=1 at DONE, then load 9 new X values only.
  - Response: the bank re-ARMs without W loads, and step0 w_col={1,4,7} again.
- Mid-stream reset and arbitration:
  - Stimulus: assert clear at step1; separately, assert load_w and load_x together while W is not full.
  - Response: after clear, outputs, flags and state are 0/IDLE with no done pulse. With both loads high, only W is written.
- Parametric:
  - Stimulus: N=4, DW=8, W=0..15, identity X.
  - Response: step k w_col={k,4+k,8+k,12+k}, and x_row is one-hot at position k with value 1.
